// File: rtl/encoder_pkg.sv
// Shared types and defaults for the encoder job scheduler and its arbiter.
// Holds the scheduler state encoding plus the encoder-facing index width.
package encoder_pkg;

    localparam int FILE_IDX_W      = 10;
    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Requester index width; a single bit even for the degenerate N_REQ=1 case.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping from N_REQ-1 back to 0 (works for non-power-of-two N_REQ).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [PTR_W-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = PTR_W'((int'(ptr) + gi) % N_REQ);
        end
    endgenerate

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        // Walk from the farthest candidate back so the nearest to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt_idx   = cand[k];
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) begin
            gnt_onehot = N_REQ'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/encoder_job_scheduler.sv
// Shares one encoder among N_REQ requesters: round-robin grant, start pulse,
// wait for finish, done pulse. ENC_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module encoder_job_scheduler
    import encoder_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int IDX_W   = FILE_IDX_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*IDX_W-1:0] req_file_index,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   err,
    output logic                   busy,
    output logic                   enc_start,
    output logic [IDX_W-1:0]       enc_file_index,
    input  logic                   enc_finish
);

    localparam int PTR_W = ptr_width(N_REQ);

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             enc_start_q, enc_start_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] winner_q, winner_d;

    logic [N_REQ-1:0] arb_onehot;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;
    logic             timeout_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

`ifdef ENC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counter holds the number of WAIT cycles already completed.
    always_comb begin
        wd_d        = wd_q;
        timeout_hit = 1'b0;
        if (state_q == START) begin
            wd_d = '0;
        end else if (state_q == WAIT) begin
            wd_d        = wd_q + 1'b1;
            timeout_hit = (wd_d == WD_W'(TIMEOUT));
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = 1'b0;
        enc_start_d = 1'b0;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d     = START;
                    grant_d     = arb_onehot;
                    winner_d    = arb_idx;
                    idx_d       = req_file_index[int'(arb_idx) * IDX_W +: IDX_W];
                    enc_start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (enc_finish || timeout_hit) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    err_d   = timeout_hit && !enc_finish;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (int'(winner_q) == N_REQ - 1) ? '0 : winner_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            enc_start_q <= 1'b0;
            idx_q       <= '0;
            ptr_q       <= '0;
            winner_q    <= '0;
`ifdef ENC_SCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            enc_start_q <= enc_start_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
`ifdef ENC_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = busy_q;
    assign enc_start      = enc_start_q;
    assign enc_file_index = idx_q;

endmodule

// File: tb/tb_encoder_job_scheduler.sv
// Directed bench for encoder_job_scheduler with a timestamp-based job model
// and a simple encoder responder; honours ENC_SCHED_TIMEOUT_EN.
module tb_encoder_job_scheduler;

    localparam int N  = 4;
    localparam int IW = 10;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] req_file_index = '0;
    logic [N-1:0]    grant, done;
    logic            err, busy, enc_start;
    logic [IW-1:0]   enc_file_index;
    logic            auto_fin = 1'b0;
    logic            spur_fin = 1'b0;
    wire             enc_finish = auto_fin | spur_fin;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int enc_lat = 0;
    int fin_cnt = 0;

    logic [IW-1:0] start_log [$];
    logic [N-1:0]  done_log  [$];

    encoder_job_scheduler #(
        .N_REQ   (N),
        .IDX_W   (IW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_file_index (req_file_index),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .enc_start      (enc_start),
        .enc_file_index (enc_file_index),
        .enc_finish     (enc_finish)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Encoder stand-in: finishes enc_lat cycles after the start cycle; 0 = never.
    initial forever begin
        @(posedge clk);
        #1;
        auto_fin = 1'b0;
        if (!rst) begin
            fin_cnt = 0;
        end else begin
            if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) auto_fin = 1'b1;
            end
            if (enc_start && enc_lat > 0) fin_cnt = enc_lat;
        end
    end

    // Job model: one owner at a time, described by the cycle numbers of its events.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_start = -100;
    int            m_done  = -100;
    int            m_w;
    bit            m_fin   = 1'b0;
    bit            m_err   = 1'b0;
    logic [IW-1:0] m_idx   = '0;
    logic [N-1:0]  e_oh;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_idx   = '0;
            check("rst_grant", grant, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_busy", busy, 0);
            check("rst_start", enc_start, 0);
            check("rst_index", enc_file_index, 0);
        end else begin
            e_oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            check("grant", grant, e_oh);
            check("busy", busy, (m_owner >= 0) ? 1 : 0);
            check("enc_start", enc_start, (m_owner >= 0 && cyc == m_start) ? 1 : 0);
            check("done", done, (m_owner >= 0 && cyc == m_done) ? e_oh : '0);
            check("err", err, (m_owner >= 0 && cyc == m_done && m_err) ? 1 : 0);
            check("enc_file_index", enc_file_index, m_idx);
            check("grant_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
            if (enc_start) start_log.push_back(enc_file_index);
            if (done != '0) done_log.push_back(done);

            if (m_owner < 0) begin
                m_w = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
                end
                if (m_w >= 0) begin
                    m_owner = m_w;
                    m_start = cyc + 1;
                    m_done  = -100;
                    m_fin   = 1'b0;
                    m_err   = 1'b0;
                    m_idx   = req_file_index[m_w * IW +: IW];
                end
            end else if (cyc == m_done) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (!m_fin && cyc > m_start) begin
                if (enc_finish) begin
                    m_fin  = 1'b1;
                    m_done = cyc + 1;
                end
`ifdef ENC_SCHED_TIMEOUT_EN
                else if (cyc - m_start == TO) begin
                    m_fin  = 1'b1;
                    m_err  = 1'b1;
                    m_done = cyc + 1;
                end
`endif
            end
        end
    end

    // Waits for a done pulse, then drops the served request bits after that edge.
    task automatic wait_done(input logic [N-1:0] exp, input int bound,
                             output int at, output logic e);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done == '0 && k < bound);
        check("done_seen", done, exp);
        at = cyc;
        e  = err;
        @(posedge clk);
        #1;
        req = req & ~exp;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int            start_at, done_at;
    logic          err_at;
    logic [IW-1:0] exp_idx [4];
    logic [N-1:0]  exp_done [4];

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant_lit", grant, 0);
        check("reset_index_lit", enc_file_index, 0);
        rst = 1'b1;

        // Single request, encoder answers 30 cycles after start.
        @(posedge clk);
        #1;
        enc_lat = 30;
        req_file_index[0 +: IW] = 10'd37;
        req = 4'b0001;
        @(posedge clk);
        #1;
        start_at = cyc;
        check("single_grant_lit", grant, 4'b0001);
        check("single_start_lit", enc_start, 1);
        check("single_index_lit", enc_file_index, 37);
        wait_done(4'b0001, 60, done_at, err_at);
        check("single_latency_lit", done_at - start_at, 31);
        check("single_busy_after", busy, 0);
        $display("single: start cycle %0d done cycle %0d", start_at, done_at);

        // All four request at once, from a fresh pointer.
        do_reset();
        enc_lat = 3;
        for (int i = 0; i < N; i++) req_file_index[i * IW +: IW] = IW'(10 + i);
        start_log.delete();
        done_log.delete();
        @(posedge clk);
        #1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_done(N'(1) << i, 20, done_at, err_at);
            $display("all: done 0x%0h at cycle %0d", N'(1) << i, done_at);
        end
        exp_idx  = '{10'd10, 10'd11, 10'd12, 10'd13};
        exp_done = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        check("all_start_count", start_log.size(), 4);
        check("all_done_count", done_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < start_log.size()) check("all_start_order", start_log[i], exp_idx[i]);
            if (i < done_log.size()) check("all_done_order", done_log[i], exp_done[i]);
        end

        // Fairness: serve requester 2, then 1 and 3 compete.
        enc_lat = 2;
        req = 4'b0100;
        wait_done(4'b0100, 20, done_at, err_at);
        done_log.delete();
        req = 4'b1010;
        wait_done(4'b1000, 20, done_at, err_at);
        wait_done(4'b0010, 20, done_at, err_at);
        check("fair_first_lit", (done_log.size() > 0) ? done_log[0] : '0, 4'b1000);
        $display("fairness: served order 3 then 1");

        // Spurious finish in IDLE, then in START.
        spur_fin = 1'b1;
        @(posedge clk);
        #1;
        spur_fin = 1'b0;
        check("spur_idle_busy", busy, 0);
        enc_lat = 0;
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("spur_start_lit", enc_start, 1);
        spur_fin = 1'b1;
        @(posedge clk);
        #1;
        spur_fin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("spur_still_busy", busy, 1);
        check("spur_no_done", done, 0);
        spur_fin = 1'b1;
        @(posedge clk);
        #1;
        spur_fin = 1'b0;
        wait_done(4'b0001, 5, done_at, err_at);
        $display("spurious: job 0 finished at cycle %0d", done_at);

        // Reset while waiting on the encoder.
        enc_lat = 0;
        req = 4'b0010;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_grant", grant, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_start", enc_start, 0);
        check("rst_mid_done", done, 0);
        req = 4'b0100;
        enc_lat = 4;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_regrant_lit", grant, 4'b0100);
        wait_done(4'b0100, 20, done_at, err_at);
        $display("reset mid-wait: regrant 0100 done at cycle %0d", done_at);

`ifdef ENC_SCHED_TIMEOUT_EN
        enc_lat = 0;
        req = 4'b0001;
        @(posedge clk);
        #1;
        start_at = cyc;
        wait_done(4'b0001, 40, done_at, err_at);
        check("timeout_cycles_lit", done_at - start_at, 17);
        check("timeout_err_lit", err_at, 1);
        $display("timeout: done at +%0d err=%0b", done_at - start_at, err_at);
        enc_lat = 16;
        req = 4'b0001;
        @(posedge clk);
        #1;
        start_at = cyc;
        wait_done(4'b0001, 40, done_at, err_at);
        check("race_cycles_lit", done_at - start_at, 17);
        check("race_err_lit", err_at, 0);
        $display("finish vs timeout: done at +%0d err=%0b", done_at - start_at, err_at);
`else
        enc_lat = 0;
        req = 4'b0001;
        repeat (40) @(posedge clk);
        #1;
        check("nowd_busy_lit", busy, 1);
        check("nowd_err_lit", err, 0);
        spur_fin = 1'b1;
        @(posedge clk);
        #1;
        spur_fin = 1'b0;
        wait_done(4'b0001, 5, done_at, err_at);
        check("nowd_err_done", err_at, 0);
        $display("no watchdog: job held until finish, done at cycle %0d", done_at);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish, required finish before limit");
        $fatal(1);
    end

endmodule

// File: doc/encoder_job_scheduler.md
Name: encoder_job_scheduler

Overview:
- Shares one encoder instance (start/finish/file_index handshake) among N_REQ requesters, e.g. host loaders or test drivers.
- Arbitrates round-robin and latches the winner's file_index.
- Issues a single start pulse to the encoder, waits for its finish, then returns a per-requester done pulse.
- Sits directly above the encoder top, between it and the request sources.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 10, file index width; matches the encoder file_index port.
- TIMEOUT, 4096, cycles allowed in WAIT before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester job request, level; held until its done.
- req_file_index  in  N_REQ*IDX_W  packed indices; requester i occupies bits [i*IDX_W +: IDX_W].
- grant  out  N_REQ  one-hot current owner; zero when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  1  one-cycle abort pulse, coincident with done.
- busy  out  1  high whenever state != IDLE.
- enc_start  out  1  one-cycle start pulse to the encoder.
- enc_file_index  out  IDX_W  index presented to the encoder; stable from START until the next grant.
- enc_finish  in  1  encoder completion pulse, one cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, done=0, err=0, busy=0, enc_start=0, enc_file_index=0, rr pointer=0 (requester 0 highest priority).
- Reset mid-job abandons the job without a done pulse. The encoder shares rst and restarts too.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If |req, pick a winner round-robin: first set bit searching from ptr upward, wrapping at N_REQ-1 to 0.
  - At the edge, register grant=onehot(winner) and enc_file_index=req_file_index[winner], then go to START.
  - If no req, stay in IDLE.
- START: enc_start=1 for exactly this cycle. Then go to WAIT.
- WAIT:
  - On the first cycle enc_finish=1, go to DONE.
  - enc_finish is ignored in IDLE, START and DONE.
- DONE:
  - done[winner]=1 for this cycle.
  - At exit: grant cleared, ptr=(winner+1) mod N_REQ, go to IDLE.
- Requester rule: deassert req on the edge ending its done cycle. A req still high in IDLE is treated as a new job.
- req dropped while granted is ignored. The job completes and done still pulses.
- Latency:
  - req seen in IDLE at cycle t gives grant at t+1 and enc_start in cycle t+1.
  - done occurs in the cycle after the enc_finish cycle.
  - Overhead is 3 cycles per job beyond encoder latency.
- req_file_index is sampled only at the grant edge. Later changes do not affect the running job.
- Simultaneous requests: exactly one granted; the others wait. No starvation: each requester waits at most N_REQ-1 jobs.
- Winner and ptr encoding width is $clog2(N_REQ), minimum 1. ptr wraps modulo N_REQ, including non-power-of-two N_REQ.

Optional Feature:
- Macro: ENC_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counter, width $clog2(TIMEOUT+1), clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no enc_finish, go to DONE and assert err together with done.
  - enc_finish and timeout in the same cycle: finish wins, err=0.
- Undefined: no counter; err tied to 0; WAIT lasts indefinitely.

Decomposition:
- Shared package encoder_pkg holds:
  - state typedef (IDLE, START, WAIT, DONE);
  - FILE_IDX_W=10;
  - default N_REQ;
  - default TIMEOUT.
- One natural sub-module, rr_arbiter: combinational; inputs req and ptr; outputs onehot winner, winner index and a valid flag.
- FSM, latches and watchdog stay in encoder_job_scheduler.

Test Plan:
- Single request: req=0001, idx0=37; encoder model finishes 30 cycles after start.
  - Required: grant=0001 and enc_start=1 one cycle after req, with enc_file_index=37.
  - done=0001 for one cycle, one cycle after enc_finish; busy low afterwards.
- All request: req=1111 with indices 10, 11, 12, 13.
  - Required: start order 10, 11, 12, 13; exactly 4 done pulses in order 0001, 0010, 0100, 1000; never two grant bits set.
- Fairness: after requester 2 is served, req=1010.
  - Required: requester 3 granted next, then 1.
- Spurious finish: enc_finish pulsed while in IDLE and in START.
  - Required: no state change, no done.
- Reset mid-WAIT: rst=0 asserted asynchronously between edges.
  - Required: grant, busy and enc_start are 0 immediately; no done.
  - After release with req=0100: grant=0100 (ptr reset to 0, searches upward).
- Timeout (macro on, TIMEOUT=16), encoder never finishes.
  - Required: done and err both pulse 16 cycles after WAIT entry.
  - With finish on cycle 16 instead: err=0.
  - Macro off: err stays 0 and busy stays 1.
